// File: rtl/fsm_job_driver_if.sv
// Job request, engine control and completion signals of fsm_job_driver.
// master = the driver itself; slave = the upstream source plus the engine.
interface fsm_job_driver_if #(
  parameter int unsigned LEN_W = 8
) ();
  logic             req_valid;
  logic             req_ready;
  logic [LEN_W-1:0] req_len;
  logic             start;
  logic             done;
  logic             eng_busy;
  logic             eng_ready;
  logic             cmpl_valid;
  logic             cmpl_err;

  modport master (
    input  req_valid, req_len, eng_busy, eng_ready,
    output req_ready, start, done, cmpl_valid, cmpl_err
  );

  modport slave (
    output req_valid, req_len, eng_busy, eng_ready,
    input  req_ready, start, done, cmpl_valid, cmpl_err
  );
endinterface

// File: rtl/fsm_job_driver.sv
// Initiator for a start/done/busy/ready engine: runs one job per request and reports completion.
// Optional FSM_JOB_DRIVER_STATS_EN adds saturating good/error completion counters.
module fsm_job_driver #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fsm_job_driver_if.master      bus
`ifdef FSM_JOB_DRIVER_STATS_EN
  ,
  output logic [15:0]           job_cnt,
  output logic [7:0]            err_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle, StArm, StStart, StRun, StFin, StDrain, StCmpl
  } state_e;

  localparam logic [7:0] TmoLimit = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [7:0]       tmo_inc;

  assign tmo_inc = (tmo_q == 8'hFF) ? 8'hFF : tmo_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          cnt_d   = bus.req_len;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = StArm;
        end
      end
      StArm: begin
        if (bus.eng_ready) begin
          state_d = StStart;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc >= TmoLimit) begin
            err_d   = 1'b1;
            state_d = StCmpl;
          end
        end
      end
      StStart: state_d = StRun;
      StRun: begin
        // Engine dropped out of RUN on its own: abort without issuing done.
        if (!bus.eng_busy) begin
          err_d   = 1'b1;
          state_d = StCmpl;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
        end else begin
          state_d = StFin;
        end
      end
      StFin: begin
        tmo_d   = '0;
        state_d = StDrain;
      end
      StDrain: begin
        if (bus.eng_ready) begin
          err_d   = 1'b0;
          state_d = StCmpl;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc >= TmoLimit) begin
            err_d   = 1'b1;
            state_d = StCmpl;
          end
        end
      end
      StCmpl:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs: decoded from registered state only.
  assign bus.req_ready  = (state_q == StIdle);
  assign bus.start      = (state_q == StStart);
  assign bus.done       = (state_q == StFin);
  assign bus.cmpl_valid = (state_q == StCmpl);
  assign bus.cmpl_err   = (state_q == StCmpl) && err_q;

`ifdef FSM_JOB_DRIVER_STATS_EN
  logic [15:0] job_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (state_q == StCmpl) begin
      if (!err_q && job_cnt_q != 16'hFFFF) job_cnt_q <= job_cnt_q + 16'd1;
      if (err_q && err_cnt_q != 8'hFF)     err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign job_cnt = job_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
